mm_res_serializer: RTL and testbench
====================================

Name: mm_res_serializer

Overview:
- Consumer end of the matrix-multiply result bus. Captures the full-width ROW_NUM x COL_NUM result word on a capture strobe and streams it out one DATA_WIDTH element per beat over a valid/ready interface.
- Double-buffered (active + shadow), so the multiply array can hand over the next result while the current one drains.
- Sits between the mm array's res output and the write-back / output FIFO.

Parameters:
- DATA_WIDTH, 8, bits per result element.
- ROW_NUM, 8, result rows.
- COL_NUM, 8, result columns.
- COL_MAJOR, 0, 0 = emit row-major (index i*COL_NUM+j), 1 = emit column-major (j outer, i inner).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- res  input  DATA_WIDTH*ROW_NUM*COL_NUM  result bus; element (i,j) at bits [(i*COL_NUM+j+1)*DATA_WIDTH-1 : (i*COL_NUM+j)*DATA_WIDTH].
- res_valid  input  1  capture strobe; res is valid this cycle.
- res_ready  output  1  block can accept a capture (shadow empty).
- out_data  output  DATA_WIDTH  current element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  final element of current matrix.
- out_row  output  $clog2(ROW_NUM) (min 1)  row index of out_data.
- out_col  output  $clog2(COL_NUM) (min 1)  column index of out_data.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Interface decided: one clock clk; reset is synchronous and active-high.
- State: active_full, shadow_full, active/shadow matrix registers, row/col counters.
- Reset: out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, res_ready=1, overflow=0. Both buffers empty; counters 0. Reset mid-drain discards both buffers with no partial output.
- res_ready = !shadow_full, from registered state only; no combinational path from res_valid or out_ready.
- Capture accepted when res_valid && res_ready at a rising edge:
  - If active empty (or emptying this edge) and shadow empty: load directly into active, counters cleared; out_valid=1 on the next cycle (1-cycle latency).
  - Otherwise: load into shadow.
- res_valid while res_ready=0: data dropped, overflow set, buffers unchanged. overflow clears only on reset.
- Output beat = out_valid && out_ready:
  - Advance the inner counter (col when row-major, row when column-major); wrap it and advance the outer counter.
  - out_data is muxed from active by (out_row, out_col).
  - out_valid, out_data, out_row, out_col hold stable while out_valid && !out_ready.
- out_last = out_valid && at the final index (ROW_NUM-1, COL_NUM-1).
- Last beat with shadow full: shadow moves into active on the same edge, counters reset; out_valid stays 1 (no bubble); res_ready rises the next cycle.
- Last beat with shadow empty and a simultaneous accepted capture: capture goes straight into active, with no bubble.
- Last beat with nothing pending: active empties, out_valid=0 next cycle.
- Throughput: 1 element/cycle sustained; ROW_NUM*COL_NUM beats per matrix.

Decomposition:
- Shared package mm_pkg: element index/offset helper functions, the row/col index width constants (clog2 with min 1), and the ORDER_ROW/ORDER_COL encodings.
- One natural sub-module: mm_idx_counter (2-D wrap counter with an order select, providing last and wrap flags).
- Buffers and the element mux stay inline.

Test Plan (DATA_WIDTH=8, ROW_NUM=2, COL_NUM=3):
- Reset, then res=elements 0x01..0x06 (index order) with res_valid one cycle and out_ready=1 -> out_valid next cycle; out_data 01,02,03,04,05,06 on consecutive cycles; (row,col) (0,0)..(1,2); out_last only on 06.
- COL_MAJOR=1, same input -> order 01,04,02,05,03,06; out_last on 06.
- Back-to-back captures A=0x01..06, B=0x11..16 on consecutive cycles, out_ready=1 -> 12 contiguous beats with no bubble; res_ready low from B capture until B becomes active.
- Third capture C while active and shadow are both full -> res_ready=0, overflow=1; C never appears on the output; A then B drain intact.
- out_ready toggled 1,0,0,1 during a drain -> out_data held through the stalls; no element lost or duplicated.
- Reset asserted after the 3rd beat of A with B in shadow -> next cycle out_valid=0, res_ready=1, overflow=0; a new capture drains from element (0,0).

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply result path: emit-order
// encodings, index width helper and element offset helpers.
package mm_pkg;

    // Emit order: which index is the inner (fast) one.
    typedef enum logic {
        ORDER_ROW = 1'b0,   // column index is inner
        ORDER_COL = 1'b1    // row index is inner
    } order_e;

    // Default result geometry of the multiply array.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROW_NUM    = 8;
    localparam int DEF_COL_NUM    = 8;

    // Index width for a dimension of n entries; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ROW_W = idx_w(DEF_ROW_NUM);
    localparam int DEF_COL_W = idx_w(DEF_COL_NUM);

    // Linear element index of (i,j) in the flattened result bus.
    function automatic int elem_index(input int i, input int j, input int col_num);
        return i * col_num + j;
    endfunction

    // Bit offset of element (i,j) in the flattened result bus.
    function automatic int elem_offset(input int i, input int j, input int col_num,
                                       input int data_width);
        return elem_index(i, j, col_num) * data_width;
    endfunction

endpackage

// File: rtl/mm_idx_counter.sv
// 2-D wrap counter walking a ROW_NUM x COL_NUM matrix in row- or column-major
// order. last flags the final (ROW_NUM-1, COL_NUM-1) position; wrap flags an
// advance out of that position.
module mm_idx_counter
    import mm_pkg::*;
#(
    parameter int     ROW_NUM = 8,
    parameter int     COL_NUM = 8,
    parameter order_e ORDER   = ORDER_ROW,
    parameter int     ROW_W   = idx_w(ROW_NUM),
    parameter int     COL_W   = idx_w(COL_NUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last,
    output logic             wrap
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_NUM - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_NUM - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_at_max;
    logic             col_at_max;

    assign row_at_max = (row_q == ROW_MAX);
    assign col_at_max = (col_q == COL_MAX);

    // Next position: clear wins over advance; the inner index wraps into the outer one.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (ORDER == ORDER_ROW) begin
                if (col_at_max) begin
                    col_d = '0;
                    row_d = row_at_max ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else begin
                if (row_at_max) begin
                    row_d = '0;
                    col_d = col_at_max ? '0 : col_q + COL_W'(1);
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_at_max && col_at_max;
    assign wrap = adv && last;

endmodule

// File: rtl/mm_res_serializer.sv
// Double-buffered serializer for the multiply array result bus: captures a
// full ROW_NUM x COL_NUM matrix on res_valid and streams it one element per
// beat over out_valid/out_ready.
//
// Buffer occupancy (active_full, shadow_full):
//   state | meaning
//   0 0   | idle, nothing to emit, capture loads active directly
//   1 0   | draining active, a capture goes into shadow
//   1 1   | draining active, shadow waiting, captures are dropped (overflow)
module mm_res_serializer
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8,
    parameter int COL_MAJOR  = 0,
    parameter int ROW_W      = idx_w(ROW_NUM),
    parameter int COL_W      = idx_w(COL_NUM)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_WIDTH*ROW_NUM*COL_NUM-1:0] res,
    input  logic                                  res_valid,
    output logic                                  res_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic [ROW_W-1:0]                      out_row,
    output logic [COL_W-1:0]                      out_col,
    output logic                                  overflow
);

    localparam order_e ORDER = (COL_MAJOR != 0) ? ORDER_COL : ORDER_ROW;

    typedef logic [DATA_WIDTH-1:0] mat_t [ROW_NUM][COL_NUM];

    mat_t             res_mat;
    mat_t             active_q, active_d;
    mat_t             shadow_q, shadow_d;
    logic             active_full_q, active_full_d;
    logic             shadow_full_q, shadow_full_d;
    logic             overflow_q, overflow_d;

    logic             beat;
    logic             last_beat;
    logic             accept;
    logic             cnt_clr;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic             cnt_last;
    logic             cnt_wrap;

    // Unpack the flat result bus into a matrix view.
    for (genvar gi = 0; gi < ROW_NUM; gi++) begin : g_row
        for (genvar gj = 0; gj < COL_NUM; gj++) begin : g_col
            assign res_mat[gi][gj] =
                res[elem_offset(gi, gj, COL_NUM, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    assign beat      = active_full_q && out_ready;
    assign last_beat = cnt_wrap;
    assign accept    = res_valid && !shadow_full_q;

    mm_idx_counter #(
        .ROW_NUM (ROW_NUM),
        .COL_NUM (COL_NUM),
        .ORDER   (ORDER),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W)
    ) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .adv   (beat),
        .row   (cnt_row),
        .col   (cnt_col),
        .last  (cnt_last),
        .wrap  (cnt_wrap)
    );

    // Buffer handover: on the final beat the shadow (or a same-cycle capture)
    // refills active so the stream continues without a bubble.
    always_comb begin
        active_d      = active_q;
        shadow_d      = shadow_q;
        active_full_d = active_full_q;
        shadow_full_d = shadow_full_q;
        overflow_d    = overflow_q || (res_valid && shadow_full_q);
        cnt_clr       = 1'b0;
        if (last_beat) begin
            if (shadow_full_q) begin
                active_d      = shadow_q;
                shadow_full_d = 1'b0;
                cnt_clr       = 1'b1;
            end else if (accept) begin
                active_d      = res_mat;
                cnt_clr       = 1'b1;
            end else begin
                active_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!active_full_q) begin
                active_d      = res_mat;
                active_full_d = 1'b1;
                cnt_clr       = 1'b1;
            end else begin
                shadow_d      = res_mat;
                shadow_full_d = 1'b1;
            end
        end
    end

    // Buffer and flag registers; reset discards both buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q      <= '{default: '0};
            shadow_q      <= '{default: '0};
            active_full_q <= 1'b0;
            shadow_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            active_full_q <= active_full_d;
            shadow_full_q <= shadow_full_d;
            overflow_q    <= overflow_d;
        end
    end

    // out_data is forced to zero while idle so a drained matrix never leaks.
    assign out_data  = active_full_q ? active_q[cnt_row][cnt_col] : '0;
    assign out_valid = active_full_q;
    assign out_last  = active_full_q && cnt_last;
    assign out_row   = cnt_row;
    assign out_col   = cnt_col;
    assign res_ready = !shadow_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mm_res_serializer.sv
// Scoreboard bench: a row-major and a column-major instance share the same
// stimulus. The reference model tracks how many matrices are held and pushes
// each accepted matrix's element sequence into per-order queues; the monitor
// pops on every output beat.
module tb_mm_res_serializer;

    localparam int DW = 8;
    localparam int R  = 2;
    localparam int C  = 3;
    localparam int N  = R * C;

    typedef struct {
        logic [DW-1:0] d;
        int            row;
        int            col;
        bit            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW*N-1:0] res = '0;
    logic            res_valid = 1'b0;
    logic            out_ready = 1'b0;

    logic            rr_r, ov_r, ol_r, of_r;
    logic [DW-1:0]   od_r;
    logic [0:0]      orow_r;
    logic [1:0]      ocol_r;
    logic            rr_c, ov_c, ol_c, of_c;
    logic [DW-1:0]   od_c;
    logic [0:0]      orow_c;
    logic [1:0]      ocol_c;

    mm_res_serializer #(.DATA_WIDTH(DW), .ROW_NUM(R), .COL_NUM(C), .COL_MAJOR(0)) u_dut_row (
        .clk(clk), .reset(reset), .res(res), .res_valid(res_valid), .res_ready(rr_r),
        .out_data(od_r), .out_valid(ov_r), .out_ready(out_ready), .out_last(ol_r),
        .out_row(orow_r), .out_col(ocol_r), .overflow(of_r)
    );

    mm_res_serializer #(.DATA_WIDTH(DW), .ROW_NUM(R), .COL_NUM(C), .COL_MAJOR(1)) u_dut_col (
        .clk(clk), .reset(reset), .res(res), .res_valid(res_valid), .res_ready(rr_c),
        .out_data(od_c), .out_valid(ov_c), .out_ready(out_ready), .out_last(ol_c),
        .out_row(orow_c), .out_col(ocol_c), .overflow(of_c)
    );

    always #5 clk = ~clk;

    beat_t exp_r[$];
    beat_t exp_c[$];
    int    held      = 0;
    int    head_left = 0;
    bit    ovf_m     = 1'b0;
    bit    rst_seen  = 1'b0;
    int    checks    = 0;
    int    failures  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_matrix(input logic [DW*N-1:0] m);
        beat_t b;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                b.d = m[(i*C+j)*DW +: DW]; b.row = i; b.col = j;
                b.last = (i == R-1) && (j == C-1);
                exp_r.push_back(b);
            end
        for (int j = 0; j < C; j++)
            for (int i = 0; i < R; i++) begin
                b.d = m[(i*C+j)*DW +: DW]; b.row = i; b.col = j;
                b.last = (i == R-1) && (j == C-1);
                exp_c.push_back(b);
            end
    endtask

    // Reference model: at most two matrices held, each emits N beats, a
    // capture is taken only when fewer than two are held before the edge.
    task automatic model_step();
        int held_n;
        int left_n;
        rst_seen = reset;
        if (reset) begin
            held = 0; head_left = 0; ovf_m = 1'b0;
            exp_r.delete(); exp_c.delete();
        end else begin
            held_n = held;
            left_n = head_left;
            if (held > 0 && out_ready) begin
                left_n--;
                if (left_n == 0) begin
                    held_n--;
                    if (held_n > 0) left_n = N;
                end
            end
            if (res_valid) begin
                if (held < 2) begin
                    push_matrix(res);
                    held_n++;
                    if (held_n == 1) left_n = N;
                end else begin
                    ovf_m = 1'b1;
                end
            end
            held = held_n;
            head_left = left_n;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic monitor(input int sel, input logic rr, input logic ov, input logic [DW-1:0] od,
                           input logic ol, input int orow, input int ocol, input logic of);
        beat_t b;
        string t;
        t = (sel == 0) ? "row" : "col";
        chk({t, "_res_ready"}, int'(rr), int'(held < 2));
        chk({t, "_out_valid"}, int'(ov), int'(held > 0));
        chk({t, "_overflow"}, int'(of), int'(ovf_m));
        if (rst_seen) begin
            chk({t, "_rst_data"}, int'(od), 0);
            chk({t, "_rst_row"}, orow, 0);
            chk({t, "_rst_col"}, ocol, 0);
            chk({t, "_rst_last"}, int'(ol), 0);
        end
        if (ov && out_ready && !reset) begin
            if ((sel == 0 ? exp_r.size() : exp_c.size()) == 0) begin
                chk({t, "_unexpected_beat"}, 1, 0);
            end else begin
                b = (sel == 0) ? exp_r.pop_front() : exp_c.pop_front();
                chk({t, "_data"}, int'(od), int'(b.d));
                chk({t, "_row"}, orow, b.row);
                chk({t, "_col"}, ocol, b.col);
                chk({t, "_last"}, int'(ol), int'(b.last));
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor(0, rr_r, ov_r, od_r, ol_r, int'(orow_r), int'(ocol_r), of_r);
        monitor(1, rr_c, ov_c, od_c, ol_c, int'(orow_c), int'(ocol_c), of_c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*N-1:0] mk(input logic [DW-1:0] base);
        logic [DW*N-1:0] m;
        for (int k = 0; k < N; k++) m[k*DW +: DW] = base + DW'(k + 1);
        return m;
    endfunction

    task automatic capture(input logic [DW*N-1:0] m);
        res = m;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        logic [DW*N-1:0] rnd;
        int pat[4] = '{1, 0, 0, 1};

        reset = 1'b1; res_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Single matrix, full throughput.
        out_ready = 1'b1;
        capture(mk(8'h00));
        repeat (8) tick();

        // Back-to-back A and B, then C while both buffers are full.
        capture(mk(8'h00));
        capture(mk(8'h10));
        capture(mk(8'h20));
        repeat (14) tick();
        reset = 1'b1; tick(); reset = 1'b0;

        // Drain under a 1,0,0,1 ready pattern with a matrix waiting in shadow.
        capture(mk(8'h30));
        capture(mk(8'h40));
        for (int k = 0; k < 24; k++) begin
            out_ready = pat[k % 4][0];
            tick();
        end
        out_ready = 1'b1;
        repeat (10) tick();

        // Reset after the third beat of A with B in shadow and overflow set.
        capture(mk(8'h50));
        capture(mk(8'h60));
        capture(mk(8'h70));
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        capture(mk(8'h80));
        repeat (10) tick();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            for (int e = 0; e < N; e++) rnd[e*DW +: DW] = DW'($urandom);
            res       = rnd;
            res_valid = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; res_valid = 1'b0; out_ready = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        #1;
        chk("row_queue_drained", exp_r.size(), 0);
        chk("col_queue_drained", exp_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
